// File: rtl/bpsk_framer_if.sv
// Payload byte stream feeding the BPSK framer (valid/ready handshake).
interface bpsk_framer_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/bpsk_framer.sv
// Frame builder and serialiser for the BPSK mapper: preamble, sync word,
// length byte and payload sent MSB-first, each bit held SYMBOL_DIV clocks.
module bpsk_framer #(
  parameter int unsigned SYMBOL_DIV   = 4,
  parameter int unsigned PREAMBLE_LEN = 8,
  parameter logic [15:0] SYNC_WORD    = 16'hD391
) (
  input  logic         clk_sig,
  input  logic         rst,
  input  logic         tx_start,
  input  logic [7:0]   tx_len,
  bpsk_framer_if.slave in_if,
  output logic         base_sig,
  output logic         sym_stb,
  output logic         busy,
  output logic         done,
  output logic         underrun
);
  typedef enum logic [2:0] {S_IDLE, S_PRE, S_SYNC, S_LEN, S_DATA} state_t;

  localparam logic [7:0] DIV_LAST = 8'(SYMBOL_DIV - 1);
  localparam logic [5:0] PRE_LAST = 6'(PREAMBLE_LEN - 1);

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic [5:0]  idx_q;
  logic [15:0] sr_q;
  logic [7:0]  len_q;
  logic [7:0]  buf_q;
  logic        buf_full_q;
  logic [8:0]  fetched_q;
  logic [8:0]  sent_q;
  logic        base_q;
  logic        stb_q;
  logic        busy_q;
  logic        done_q;
  logic        underrun_q;

  logic xfer;
  logic bit_end;
  logic field_last;
  logic frame_end;

  assign in_if.in_ready = ~buf_full_q & busy_q & (fetched_q < {1'b0, len_q});
  assign xfer           = in_if.in_valid & in_if.in_ready;
  assign bit_end        = (state_q != S_IDLE) && (cnt_q == DIV_LAST);

  always_comb begin
    field_last = 1'b0;
    frame_end  = 1'b0;
    case (state_q)
      S_PRE:  field_last = (idx_q == PRE_LAST);
      S_SYNC: field_last = (idx_q == 6'd15);
      S_LEN: begin
        field_last = (idx_q == 6'd7);
        frame_end  = (idx_q == 6'd7) && (len_q == 8'd0);
      end
      S_DATA: begin
        field_last = (idx_q == 6'd7);
        frame_end  = (idx_q == 6'd7) && (sent_q == {1'b0, len_q});
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_sig) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      sr_q       <= '0;
      len_q      <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      fetched_q  <= '0;
      sent_q     <= '0;
      base_q     <= 1'b0;
      stb_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (xfer) begin
        buf_q      <= in_if.in_data;
        buf_full_q <= 1'b1;
        fetched_q  <= fetched_q + 9'd1;
      end
      case (state_q)
        S_IDLE: begin
          base_q <= 1'b0;
          stb_q  <= 1'b0;
          busy_q <= 1'b0;
          if (tx_start) begin
            state_q    <= S_PRE;
            len_q      <= tx_len;
            cnt_q      <= '0;
            idx_q      <= '0;
            fetched_q  <= '0;
            sent_q     <= '0;
            buf_full_q <= 1'b0;
            underrun_q <= 1'b0;
            base_q     <= 1'b1;
            stb_q      <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        default: begin
          if (!bit_end) begin
            cnt_q <= cnt_q + 8'd1;
            stb_q <= 1'b0;
          end else begin
            cnt_q <= '0;
            stb_q <= 1'b1;
            idx_q <= field_last ? '0 : idx_q + 6'd1;
            if (!field_last) begin
              if (state_q == S_PRE) begin
                base_q <= ~base_q;
              end else begin
                base_q <= sr_q[14];
                sr_q   <= sr_q << 1;
              end
            end else if (state_q == S_PRE) begin
              state_q <= S_SYNC;
              sr_q    <= SYNC_WORD;
              base_q  <= SYNC_WORD[15];
            end else if (state_q == S_SYNC) begin
              state_q <= S_LEN;
              sr_q    <= {len_q, 8'h00};
              base_q  <= len_q[7];
            end else if (frame_end) begin
              state_q    <= S_IDLE;
              stb_q      <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              base_q     <= 1'b0;
              buf_full_q <= 1'b0;
            end else begin
              // Byte boundary: buffer drains into the shifter; a byte landing now is kept for the next slot.
              state_q    <= S_DATA;
              sent_q     <= sent_q + 9'd1;
              buf_full_q <= xfer;
              if (buf_full_q) begin
                sr_q   <= {buf_q, 8'h00};
                base_q <= buf_q[7];
              end else begin
                sr_q       <= '0;
                base_q     <= 1'b0;
                underrun_q <= 1'b1;
              end
            end
          end
        end
      endcase
    end
  end

  assign base_sig = base_q;
  assign sym_stb  = stb_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign underrun = underrun_q;
endmodule

// File: tb/tb_bpsk_framer.sv
// Directed, table-driven bench for bpsk_framer plus a SYMBOL_DIV=1 instance.
module tb_bpsk_framer;
  localparam int unsigned DIV  = 4;
  localparam int unsigned PRE  = 8;
  localparam logic [15:0] SYNC = 16'hD391;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_start;
  logic [7:0] tx_len;
  logic       base_sig, sym_stb, busy, done, underrun;
  logic       tx_start1;
  logic [7:0] tx_len1;
  logic       base1, stb1, busy1, done1, ur1;
  int         n_cmp = 0;
  int         n_err = 0;

  bpsk_framer_if bus ();
  bpsk_framer_if bus1 ();

  always #5 clk = ~clk;

  bpsk_framer #(.SYMBOL_DIV(DIV), .PREAMBLE_LEN(PRE), .SYNC_WORD(SYNC)) dut (
    .clk_sig(clk), .rst(rst), .tx_start(tx_start), .tx_len(tx_len), .in_if(bus),
    .base_sig(base_sig), .sym_stb(sym_stb), .busy(busy), .done(done), .underrun(underrun)
  );

  bpsk_framer #(.SYMBOL_DIV(1), .PREAMBLE_LEN(PRE), .SYNC_WORD(SYNC)) dut1 (
    .clk_sig(clk), .rst(rst), .tx_start(tx_start1), .tx_len(tx_len1), .in_if(bus1),
    .base_sig(base1), .sym_stb(stb1), .busy(busy1), .done(done1), .underrun(ur1)
  );

  typedef struct {
    string       name;
    int          len;
    logic [23:0] data;
    int          nsupply;
    bit          valid_hi;
    int          inject_at;
    bit          exp_ur;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_src(input vec_t v, input int sent);
    if (sent < v.nsupply) begin
      bus.in_valid = 1'b1;
      bus.in_data  = v.data[23-8*sent -: 8];
    end else begin
      bus.in_valid = v.valid_hi;
      bus.in_data  = 8'hEE;
    end
  endtask

  task automatic apply_vec(input vec_t v, output logic [63:0] got);
    logic [63:0] exp_s;
    logic [7:0]  pb;
    logic        cur, u_first, ur_end, fin;
    logic [2:0]  start_s, done_s;
    int nbits, nb, cyc, done_cyc, ur_cyc, ur_exp, xfers, rdy_cnt, holderr, idle_rdy, sent, n_exp;
    nbits = int'(PRE) + 24 + 8 * v.len;
    n_exp = (v.nsupply < v.len) ? v.nsupply : v.len;
    exp_s = '0;
    for (int i = 0; i < int'(PRE); i++) exp_s = {exp_s[62:0], ~i[0]};
    for (int i = 15; i >= 0; i--) exp_s = {exp_s[62:0], SYNC[i]};
    pb = 8'(v.len);
    for (int i = 7; i >= 0; i--) exp_s = {exp_s[62:0], pb[i]};
    for (int b = 0; b < v.len; b++) begin
      pb = (b < v.nsupply) ? v.data[23-8*b -: 8] : 8'h00;
      for (int i = 7; i >= 0; i--) exp_s = {exp_s[62:0], pb[i]};
    end
    ur_exp = v.exp_ur ? 1 + (int'(PRE) + 24 + 8 * v.nsupply) * int'(DIV) : -1;

    got = '0; nb = 0; cur = 1'b0; u_first = 1'b0; ur_end = 1'b0; fin = 1'b0;
    start_s = '0; done_s = 3'b111; done_cyc = -1; ur_cyc = -1;
    xfers = 0; rdy_cnt = 0; holderr = 0; idle_rdy = 0; sent = 0;
    tx_start = 1'b1;
    tx_len   = 8'(v.len);
    drive_src(v, sent);
    for (cyc = 0; cyc < 3000 && !fin; ) begin
      if (bus.in_ready) rdy_cnt++;
      if (bus.in_ready && !busy) idle_rdy++;
      if (bus.in_valid && bus.in_ready) begin
        xfers++;
        sent++;
      end
      step();
      cyc++;
      tx_start = (cyc == v.inject_at);
      tx_len   = 8'hFF;
      drive_src(v, sent);
      if (cyc == 1) begin
        start_s = {base_sig, sym_stb, busy};
        u_first = underrun;
      end
      if (underrun && ur_cyc < 0) ur_cyc = cyc;
      if (done) begin
        fin      = 1'b1;
        done_cyc = cyc;
        done_s   = {busy, base_sig, sym_stb};
        ur_end   = underrun;
      end else if (sym_stb) begin
        got = {got[62:0], base_sig};
        nb++;
        cur = base_sig;
      end else if (busy && base_sig !== cur) begin
        holderr++;
      end
    end
    tx_start     = 1'b0;
    bus.in_valid = 1'b0;
    chk({v.name, "_start"},    64'(start_s),  64'(3'b111));
    chk({v.name, "_nbits"},    64'(nb),       64'(nbits));
    chk({v.name, "_stream"},   got,           exp_s);
    chk({v.name, "_done_at"},  64'(done_cyc), 64'(nbits * int'(DIV) + 1));
    chk({v.name, "_done_idle"},64'(done_s),   64'(0));
    chk({v.name, "_ur_end"},   64'(ur_end),   64'(v.exp_ur));
    chk({v.name, "_ur_onset"}, 64'(ur_cyc),   64'(ur_exp));
    chk({v.name, "_ur_clear"}, 64'(u_first),  64'(0));
    chk({v.name, "_xfers"},    64'(xfers),    64'(n_exp));
    chk({v.name, "_idle_rdy"}, 64'(idle_rdy), 64'(0));
    chk({v.name, "_hold"},     64'(holderr),  64'(0));
    if (v.valid_hi || v.len == 0)
      chk({v.name, "_rdy_cnt"}, 64'(rdy_cnt), 64'(v.valid_hi ? v.len : 0));
    step();
    chk({v.name, "_done_pulse"}, 64'({done, busy}), 64'(0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t        vecs [5];
    logic [63:0] got;
    logic [63:0] s1;
    int          n1, nostb, d1;
    vecs[0] = '{"basic",      2, 24'hA53C00, 2, 1'b0, -1, 1'b0};
    vecs[1] = '{"len0",       0, 24'h000000, 0, 1'b0, -1, 1'b0};
    vecs[2] = '{"underrun",   2, 24'hA5FF00, 1, 1'b0, -1, 1'b1};
    vecs[3] = '{"valid_hi",   3, 24'h112233, 3, 1'b1, -1, 1'b0};
    vecs[4] = '{"start_busy", 2, 24'hA53C00, 2, 1'b0, 41, 1'b0};

    rst = 1'b1; tx_start = 1'b0; tx_len = '0; bus.in_valid = 1'b0; bus.in_data = '0;
    tx_start1 = 1'b0; tx_len1 = '0; bus1.in_valid = 1'b0; bus1.in_data = '0;
    repeat (3) step();
    chk("reset_state", 64'({base_sig, sym_stb, busy, done, underrun, bus.in_ready}), 64'(0));
    rst = 1'b0;
    step();

    for (int i = 0; i < 5; i++) begin
      apply_vec(vecs[i], got);
      if (i == 0) chk("basic_literal", got, 64'h0000_AAD3_9102_A53C);
    end

    // tx_start presented in the done cycle starts the next frame immediately
    tx_start = 1'b1; tx_len = 8'd0;
    step();
    tx_start = 1'b0;
    for (int c = 0; c < 400 && !done; c++) step();
    chk("chain_done", 64'(done), 64'(1));
    tx_start = 1'b1;
    step();
    tx_start = 1'b0;
    chk("chain_restart", 64'({base_sig, sym_stb, busy, done}), 64'(4'b1110));
    for (int c = 0; c < 400 && !done; c++) step();
    chk("chain_done2", 64'(done), 64'(1));
    step();

    // Reset in the middle of the payload
    tx_start = 1'b1; tx_len = 8'd2;
    step();
    tx_start = 1'b0;
    repeat (150) step();
    chk("pre_rst_busy", 64'({busy, underrun, bus.in_ready}), 64'(3'b111));
    rst = 1'b1;
    step();
    chk("rst_mid", 64'({base_sig, sym_stb, busy, done, underrun, bus.in_ready}), 64'(0));
    rst = 1'b0;
    step();
    apply_vec(vecs[0], got);
    chk("after_rst_literal", got, 64'h0000_AAD3_9102_A53C);

    // SYMBOL_DIV=1: strobe on every busy cycle
    tx_start1 = 1'b1; tx_len1 = 8'd0;
    step();
    tx_start1 = 1'b0;
    s1 = '0; n1 = 0; nostb = 0; d1 = -1;
    for (int c = 1; c < 200; c++) begin
      if (done1) begin
        d1 = c;
        break;
      end
      if (busy1) begin
        if (stb1) n1++;
        else nostb++;
        s1 = {s1[62:0], base1};
      end
      step();
    end
    chk("div1_done_at", 64'(d1), 64'(33));
    chk("div1_stb", 64'(n1), 64'(32));
    chk("div1_nostb", 64'(nostb), 64'(0));
    chk("div1_stream", s1, 64'h0000_0000_AAD3_9100);
    chk("div1_flags", 64'({ur1, bus1.in_ready, busy1, base1}), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/bpsk_framer.md
Name: bpsk_framer

Overview:
- Upstream stage of the BPSK mapper. Produces the serial baseband bit stream that drives the mapper's base_sig input.
- Accepts payload bytes over a valid/ready stream and wraps them in a frame: alternating preamble, 16-bit sync word, length byte, payload.
- Serialises the frame MSB-first. Each bit is held for SYMBOL_DIV clocks, with a strobe on every new bit.

Parameters:
- SYMBOL_DIV, 4: clock cycles per transmitted bit; legal range 1..256.
- PREAMBLE_LEN, 8: number of preamble bits (pattern 1,0,1,0,..., starting with 1); legal range 1..64.
- SYNC_WORD, 16'hD391: sync word, sent MSB first.

Ports:
- clk_sig  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- tx_start  in  1  one-cycle request to send a frame; sampled only in IDLE.
- tx_len  in  8  payload byte count; captured together with tx_start; 0..255.
- in_data  in  8  payload byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  the block accepts in_data this cycle. A transfer occurs when in_valid and in_ready are both high.
- base_sig  out  1  current serial bit, fed to the mapper.
- sym_stb  out  1  one-cycle pulse in the first clock of each new bit.
- busy  out  1  a frame is in progress.
- done  out  1  one-cycle pulse when a frame completes.
- underrun  out  1  sticky flag: a payload byte was not available when needed. Cleared by the next accepted tx_start.

Behaviour:
- Reset values: base_sig=0, sym_stb=0, busy=0, done=0, underrun=0, in_ready=0. The FSM goes to IDLE, counters clear and the prefetch buffer is emptied.
- Reset is honoured in any state, mid-frame included. Output is back at idle levels in the cycle after rst is sampled high.
- States: IDLE, PRE, SYNC, LEN, DATA.
  - IDLE -> PRE on tx_start.
  - PRE -> SYNC after PREAMBLE_LEN bits.
  - SYNC -> LEN after 16 bits.
  - LEN -> DATA after 8 bits when tx_len != 0; LEN -> IDLE when tx_len == 0.
  - DATA -> IDLE after 8*tx_len bits.
- Start latency: if tx_start is sampled in IDLE at cycle T, then at T+1:
  - base_sig = first preamble bit (1);
  - sym_stb = 1;
  - busy = 1.
- Bit timing:
  - A symbol counter counts 0..SYMBOL_DIV-1.
  - The bit advances when the count wraps.
  - sym_stb is high exactly when the count is 0 during a frame.
  - With SYMBOL_DIV=1, sym_stb is high on every busy cycle.
- Frame length: total bits N = PREAMBLE_LEN + 24 + 8*tx_len. The last bit occupies cycles up to T+N*SYMBOL_DIV.
- Completion, at cycle T+N*SYMBOL_DIV+1:
  - done=1 for one cycle;
  - busy=0;
  - base_sig=0;
  - FSM in IDLE.
  A new tx_start is accepted in that same cycle.
- tx_start is ignored while busy; tx_len is ignored unless tx_start is accepted.
- Prefetch buffer (one byte):
  - in_ready = buffer empty AND busy AND bytes_fetched < tx_len.
  - Prefetch may begin in PRE.
  - At every payload byte boundary, the first bit of a byte, the shift register loads from the buffer and the buffer empties. A new transfer may land in the same cycle.
- Underrun: if the buffer is empty at a payload byte boundary:
  - the block loads 0x00 instead;
  - it sets underrun;
  - that byte still counts toward tx_len, so the frame length is unchanged.
  - A byte arriving late for a slot is used for the next slot, never the skipped one.
  - In total, exactly tx_len transfers are accepted per frame; none are accepted in IDLE.
- Width rules: bytes_fetched and bytes_sent are 9 bits wide so that the compare against tx_len=255 does not wrap.

Test Plan:
1. SYMBOL_DIV=4, PREAMBLE_LEN=8, tx_len=2, bytes A5 and 3C presented early -> base_sig sequence is 10101010 1101001110010001 00000010 10100101 00111100, 48 bits. Each bit lasts 4 cycles with 48 sym_stb pulses. done at T+193; underrun=0; 2 transfers.
2. tx_len=0 -> 32 bits (preamble, sync, length 0x00). done at T+129; in_ready never high.
3. tx_len=2, only A5 supplied, second byte withheld -> second payload byte transmits as 00000000. underrun=1 from that byte boundary; done still at T+193. The next accepted tx_start clears underrun.
4. in_valid held high throughout, tx_len=3 -> in_ready pulses exactly 3 times, never while the buffer is full, and bytes go out in order.
5. tx_start pulsed at bit 10 of an active frame -> ignored, frame identical to an undisturbed run. tx_start in the done cycle -> next frame starts with base_sig=1 at the following cycle.
6. rst asserted during DATA -> the next cycle shows base_sig=0, busy=0, in_ready=0, sym_stb=0, underrun=0. A subsequent frame is bit-exact with scenario 1.
